mode_alu_display: RTL and testbench

//   Button-driven mode sequencer for the lab board display. Two buttons step forward/back

---
 rtl/mode_alu_pkg.sv | 5 +
 rtl/btn_edge.sv | 49 ++++
 rtl/mode_alu_display.sv | 74 +++++++
 tb/tb_mode_alu_display.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mode_alu_pkg.sv
// mode_alu_pkg: mode encoding shared by the display mode sequencer.
package mode_alu_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, SUM, DIFF, MUL, GRAY, BIN} t_mode;
  localparam int MODE_CNT = 6;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchroniser, optional debouncer (BTN_DEBOUNCE_EN), rising-edge pulse.
module btn_edge #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic btn,
  output logic pulse
);
  logic s1_q, s2_q, lvl, lvl_q;
  always_ff @(posedge clk) begin
    if (srst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      s1_q  <= btn;
      s2_q  <= s1_q;
      lvl_q <= lvl;
    end
  end
`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic deb_q;
  // Level flips on the DEB_CYCLES-th consecutive sample that disagrees with it.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (s2_q == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      cnt_q <= '0;
      deb_q <= s2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign lvl = deb_q;
`else
  if (DEB_CYCLES >= 1) begin : g_sync
    assign lvl = s2_q;
  end else begin : g_off
    assign lvl = 1'b0;
  end
`endif
  assign pulse = lvl & ~lvl_q;
endmodule

// File: rtl/mode_alu_display.sv
// mode_alu_display: button-stepped six-mode ALU/counter display; BTN_DEBOUNCE_EN adds button debouncing.
module mode_alu_display
  import mode_alu_pkg::*;
#(
  parameter int W          = 3,
  parameter int Y_W        = 8,
  parameter int BLINK_DIV  = 256,
  parameter int DEB_CYCLES = 4
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           btn_next,
  input  logic           btn_prev,
  input  logic [W-1:0]   x1,
  input  logic [W-1:0]   x2,
  output logic [Y_W-1:0] y,
  output logic [2:0]     mode,
  output logic           ovf
);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int RW = (2 * W > Y_W ? 2 * W : Y_W) + 1;
  t_mode mode_q, mode_d;
  logic [Y_W-1:0] y_q, y_d, cnt_q;
  logic [BW-1:0] bcnt_q;
  logic [RW-1:0] r;
  logic ovf_q, ovf_d, blink_q, nxt, prv, arith, bwrap;
  btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_next (.clk(clk), .srst(srst), .btn(btn_next), .pulse(nxt));
  btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_prev (.clk(clk), .srst(srst), .btn(btn_prev), .pulse(prv));
  assign bwrap = bcnt_q == BW'(BLINK_DIV - 1);
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      bcnt_q  <= bwrap ? '0 : bcnt_q + 1'b1;
      blink_q <= blink_q ^ bwrap;
    end
  end
  always_comb begin
    mode_d = mode_q;
    if (int'(mode_q) >= MODE_CNT) mode_d = IDLE;
    else if (nxt && !prv) mode_d = (mode_q == BIN) ? IDLE : t_mode'(mode_q + 3'd1);
    else if (prv && !nxt) mode_d = (mode_q == IDLE) ? BIN : t_mode'(mode_q - 3'd1);
  end
  // Result is formed at full width so saturation sees every carried-out bit.
  always_comb begin
    r = (mode_d == SUM)  ? RW'(x1) + RW'(x2) :
        (mode_d == DIFF) ? ((x1 >= x2) ? RW'(x1 - x2) : RW'(x2 - x1)) :
                           RW'(x1) * RW'(x2);
    arith = mode_d inside {SUM, DIFF, MUL};
    ovf_d = arith && ((r >> Y_W) != '0);
    y_d = ovf_d             ? '1 :
          arith             ? r[Y_W-1:0] :
          (mode_d == GRAY)  ? cnt_q ^ (cnt_q >> 1) :
          (mode_d == BIN)   ? cnt_q :
                              Y_W'(blink_q);
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      mode_q <= IDLE;
      y_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
    end
  end
  assign y    = y_q;
  assign mode = mode_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_mode_alu_display.sv
// tb_mode_alu_display: directed checks of mode stepping, ALU results, saturation and counters.
module tb_mode_alu_display;
  logic clk = 1'b0, srst = 1'b1, bn = 1'b0, bp = 1'b0;
  logic [2:0] x1 = '0, x2 = '0, m0, m1;
  logic [3:0] x1b = '0, x2b = '0;
  logic [7:0] y0, a;
  logic [5:0] y1;
  logic o0, o1, b, nb, found;
  int tests = 0, fails = 0, n;
`ifdef BTN_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  mode_alu_display #(.W(3), .Y_W(8), .BLINK_DIV(4), .DEB_CYCLES(4)) u0 (
    .clk(clk), .srst(srst), .btn_next(bn), .btn_prev(bp), .x1(x1), .x2(x2),
    .y(y0), .mode(m0), .ovf(o0));
  mode_alu_display #(.W(4), .Y_W(6), .BLINK_DIV(256), .DEB_CYCLES(4)) u1 (
    .clk(clk), .srst(srst), .btn_next(bn), .btn_prev(bp), .x1(x1b), .x2(x2b),
    .y(y1), .mode(m1), .ovf(o1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic press(input logic pn, input logic pp);
    bn = pn;
    bp = pp;
    cyc(12);
    bn = 1'b0;
    bp = 1'b0;
    cyc(8);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      bn = i[0];
      bp = ~i[0];
      x1 = 3'(i + 3);
      x2 = 3'(7 - i);
      x1b = 4'(i * 5);
      @(negedge clk);
      chk("rst_y", y0, 0);
      chk("rst_mode", m0, 0);
      chk("rst_ovf", o0, 0);
    end
    bn = 1'b0;
    bp = 1'b0;
    cyc(2);
    srst = 1'b0;
    x1 = 3'd5; x2 = 3'd6; x1b = 4'd15; x2b = 4'd15;
    bn = 1'b1;
    cyc(LAT);
    chk("lat_old", m0, 0);
    cyc(1);
    chk("lat_new", m0, 1);
    chk("sum_y", y0, 11);
    chk("sum_ovf", o0, 0);
    chk("sum_y_w4", y1, 30);
    chk("sum_ovf_w4", o1, 0);
    cyc(10);
    bn = 1'b0;
    cyc(8);
    chk("held_one_step", m0, 1);
    press(1, 0);
    chk("diff_mode", m0, 2);
    chk("diff_y", y0, 1);
    chk("diff_y_w4", y1, 0);
    x1 = 3'd6; x2 = 3'd2;
    cyc(1);
    chk("diff_y_rev", y0, 4);
    x1 = 3'd5; x2 = 3'd6;
    press(1, 0);
    chk("mul_mode", m0, 3);
    chk("mul_y", y0, 30);
    chk("mul_ovf", o0, 0);
    chk("mul_mode_w4", m1, 3);
    chk("mul_sat_w4", y1, 63);
    chk("mul_ovf_w4", o1, 1);
    x1 = 3'd7; x2 = 3'd7;
    cyc(1);
    chk("mul_y_77", y0, 49);
    x1 = 3'd5; x2 = 3'd6;
    press(1, 0);
    chk("gray_mode", m0, 4);
    chk("gray_ovf_w4", o1, 0);
    press(1, 0);
    chk("bin_mode", m0, 5);
    press(1, 0);
    chk("idle_wrap", m0, 0);
    chk("idle_y_hi", y0[7:1], 0);
    b = y0[0];
    n = 0;
    while (y0[0] == b && n < 10) begin
      cyc(1);
      n++;
    end
    chk("blink_edge_seen", (n < 10) ? 1 : 0, 1);
    b = y0[0];
    nb = ~b;
    for (int i = 1; i < 4; i++) begin
      cyc(1);
      chk("blink_hold", y0[0], b);
    end
    cyc(1);
    chk("blink_toggle", y0[0], nb);
    press(0, 1);
    chk("prev_wrap", m0, 5);
    press(1, 1);
    chk("both_same", m0, 5);
    press(1, 0);
    chk("bin_to_idle", m0, 0);
    press(1, 0);
    chk("pre_srst_mode", m0, 1);
    bn = 1'b1;
    cyc(1);
    srst = 1'b1;
    bn = 1'b0;
    cyc(1);
    chk("srst_mode", m0, 0);
    chk("srst_y", y0, 0);
    chk("srst_ovf", o0, 0);
    srst = 1'b0;
    cyc(LAT + 6);
    chk("press_lost", m0, 0);
`ifdef BTN_DEBOUNCE_EN
    bn = 1'b1;
    cyc(3);
    bn = 1'b0;
    cyc(12);
    chk("glitch_ignored", m0, 0);
`else
    bn = 1'b1;
    cyc(1);
    bn = 1'b0;
    cyc(6);
    chk("pulse_counts", m0, 1);
    press(0, 1);
    chk("pulse_back", m0, 0);
`endif
    repeat (4) press(1, 0);
    chk("gray_mode2", m0, 4);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      cyc(1);
      if (y0 == 8'h80) found = 1'b1;
    end
    chk("gray_80_seen", found, 1);
    cyc(1);
    chk("gray_wrap_0", y0, 0);
    cyc(1);
    chk("gray_1", y0, 1);
    chk("gray_ovf", o0, 0);
    press(1, 0);
    chk("bin_mode2", m0, 5);
    a = y0;
    cyc(1);
    chk("bin_inc", y0, 8'(a + 8'd1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
